// File: rtl/conv_ser_pkg.sv
// rtl/conv_ser_pkg.sv - shared types, defaults and helpers for the conv serializer scheduler
package conv_ser_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      PARITY = 2'd2
   } ser_state_e;

   localparam int DEF_N_REQ  = 4;
   localparam int DEF_DATA_W = 8;

   function automatic int beats(input int data_w);
      return data_w / 2;
   endfunction

endpackage

// File: rtl/conv_ser_scheduler_if.sv
// rtl/conv_ser_scheduler_if.sv - request bus and serializer-side outputs of the scheduler
interface conv_ser_scheduler_if #(
   parameter int N_REQ  = conv_ser_pkg::DEF_N_REQ,
   parameter int DATA_W = conv_ser_pkg::DEF_DATA_W,
   parameter int ID_W   = $clog2(N_REQ)
);
   logic [N_REQ-1:0]        REQ_VALID;
   logic [N_REQ*DATA_W-1:0] REQ_DATA;
   logic [N_REQ-1:0]        REQ_READY;
   logic                    PAR_IN1;
   logic                    PAR_IN2;
   logic                    FRAME_START;
   logic [ID_W-1:0]         FRAME_ID;
   logic                    BUSY;

   modport master (
      output REQ_VALID, REQ_DATA,
      input  REQ_READY, PAR_IN1, PAR_IN2, FRAME_START, FRAME_ID, BUSY
   );

   modport slave (
      input  REQ_VALID, REQ_DATA,
      output REQ_READY, PAR_IN1, PAR_IN2, FRAME_START, FRAME_ID, BUSY
   );
endinterface

// File: rtl/conv_rr_arbiter.sv
// rtl/conv_rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module conv_rr_arbiter
   import conv_ser_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_id,
   output logic             any
);
   always_comb begin
      int idx;
      idx    = 0;
      gnt    = '0;
      gnt_id = '0;
      any    = |req;
      // Walk from the farthest offset back to ptr so the closest request wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
            gnt_id   = ID_W'(idx);
         end
      end
   end
endmodule

// File: rtl/conv_ser_scheduler.sv
// rtl/conv_ser_scheduler.sv - round-robin scheduler feeding one conv_serializer two bits per cycle
// Optional trailing parity beat enabled by CONV_SER_PARITY_EN.
module conv_ser_scheduler
   import conv_ser_pkg::*;
#(
   parameter int N_REQ  = DEF_N_REQ,
   parameter int DATA_W = DEF_DATA_W,
   parameter int ID_W   = $clog2(N_REQ)
) (
   input  logic                 CLK,
   input  logic                 RESET,
   conv_ser_scheduler_if.slave  bus
);
   localparam int NB    = beats(DATA_W);
   localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

   ser_state_e        state, state_d;
   logic [ID_W-1:0]   ptr, ptr_d;
   logic [DATA_W-1:0] sh, sh_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              par1, par1_d, par2, par2_d, fstart, fstart_d, busy, busy_d;
   logic [ID_W-1:0]   fid, fid_d;
`ifdef CONV_SER_PARITY_EN
   logic              pbit, pbit_d;
`endif

   logic [N_REQ-1:0]  gnt;
   logic [ID_W-1:0]   gnt_id;
   logic              any;
   logic [DATA_W-1:0] word;

   conv_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
      .req    (bus.REQ_VALID),
      .ptr    (ptr),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .any    (any)
   );

   always_comb begin
      word = '0;
      for (int i = 0; i < N_REQ; i++)
         if (gnt[i]) word = bus.REQ_DATA[i*DATA_W +: DATA_W];
   end

   // Output registers are loaded with the beat they will show next cycle, so
   // the grant edge already presents the LSB pair.
   always_comb begin
      state_d  = state;
      ptr_d    = ptr;
      sh_d     = sh;
      cnt_d    = cnt;
      par1_d   = 1'b0;
      par2_d   = 1'b0;
      fstart_d = 1'b0;
      busy_d   = 1'b0;
      fid_d    = '0;
`ifdef CONV_SER_PARITY_EN
      pbit_d   = pbit;
`endif
      bus.REQ_READY = '0;
      case (state)
         IDLE: begin
            if (any && RESET) begin
               bus.REQ_READY = gnt;
               state_d  = SEND;
               ptr_d    = ID_W'((int'(gnt_id) + 1) % N_REQ);
               sh_d     = word >> 2;
               cnt_d    = CNT_W'(NB - 1);
               par1_d   = word[0];
               par2_d   = word[1];
               fstart_d = 1'b1;
               busy_d   = 1'b1;
               fid_d    = gnt_id;
`ifdef CONV_SER_PARITY_EN
               pbit_d   = ^word;
`endif
            end
         end
         SEND: begin
            if (cnt == '0) begin
`ifdef CONV_SER_PARITY_EN
               state_d = PARITY;
               par1_d  = pbit;
               par2_d  = 1'b1;
               busy_d  = 1'b1;
               fid_d   = fid;
`else
               state_d = IDLE;
`endif
            end else begin
               par1_d = sh[0];
               par2_d = sh[1];
               sh_d   = sh >> 2;
               cnt_d  = cnt - CNT_W'(1);
               busy_d = 1'b1;
               fid_d  = fid;
            end
         end
`ifdef CONV_SER_PARITY_EN
         PARITY: state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state  <= IDLE;
         ptr    <= '0;
         sh     <= '0;
         cnt    <= '0;
         par1   <= 1'b0;
         par2   <= 1'b0;
         fstart <= 1'b0;
         busy   <= 1'b0;
         fid    <= '0;
`ifdef CONV_SER_PARITY_EN
         pbit   <= 1'b0;
`endif
      end else begin
         state  <= state_d;
         ptr    <= ptr_d;
         sh     <= sh_d;
         cnt    <= cnt_d;
         par1   <= par1_d;
         par2   <= par2_d;
         fstart <= fstart_d;
         busy   <= busy_d;
         fid    <= fid_d;
`ifdef CONV_SER_PARITY_EN
         pbit   <= pbit_d;
`endif
      end
   end

   assign bus.PAR_IN1     = par1;
   assign bus.PAR_IN2     = par2;
   assign bus.FRAME_START = fstart;
   assign bus.FRAME_ID    = fid;
   assign bus.BUSY        = busy;
endmodule

// File: tb/tb_conv_ser_scheduler.sv
// tb/tb_conv_ser_scheduler.sv - self-checking bench for conv_ser_scheduler (CONV_SER_PARITY_EN aware)
module tb_conv_ser_scheduler;
   localparam int N  = 4;
   localparam int DW = 8;
`ifdef CONV_SER_PARITY_EN
   localparam int PERIOD = 6;
`else
   localparam int PERIOD = 5;
`endif

   typedef struct packed {
      logic       p2;
      logic       p1;
      logic       fs;
      logic [1:0] id;
      logic       busy;
   } outs_t;

   typedef struct {
      int         ch;
      logic [7:0] word;
      logic [3:0] ready;
      logic [1:0] pairs [4];
      logic       par;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv_ser_scheduler_if #(.N_REQ(N), .DATA_W(DW), .ID_W(2)) bus ();

   conv_ser_scheduler #(.N_REQ(N), .DATA_W(DW), .ID_W(2)) dut (
      .CLK   (clk),
      .RESET (rst_n),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_err = 0;
   int cyc = 0;
   int m_ptr = 0;
   outs_t q[$];
   int dut_grants[$];
   int dut_gcyc[$];
   vec_t tbl[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] outs_now();
      return 32'({bus.PAR_IN2, bus.PAR_IN1, bus.FRAME_START, bus.FRAME_ID, bus.BUSY});
   endfunction

   function automatic int pick(input logic [3:0] v, input int p);
      for (int k = 0; k < N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic model_reset();
      q.delete();
      m_ptr = 0;
   endtask

   // One cycle: drive at negedge, compare against the frame model, advance.
   task automatic cycle(input logic [3:0] v, input logic [31:0] d);
      outs_t e;
      logic [3:0] er;
      logic [7:0] w8;
      int w;
      bus.REQ_VALID = v;
      bus.REQ_DATA  = d;
      #1;
      e  = (q.size() > 0) ? q[0] : '0;
      er = '0;
      w  = -1;
      if (q.size() == 0 && v != 0) begin
         w  = pick(v, m_ptr);
         er = 4'b0001 << w;
      end
      chk("ready", 32'(bus.REQ_READY), 32'(er));
      chk("outs", outs_now(), 32'(e));
      for (int i = 0; i < N; i++)
         if (bus.REQ_READY[i]) begin
            dut_grants.push_back(i);
            dut_gcyc.push_back(cyc);
         end
      if (q.size() > 0) begin
         void'(q.pop_front());
      end else if (w >= 0) begin
         w8 = d[w*8 +: 8];
         for (int k = 0; k < DW / 2; k++)
            q.push_back('{w8[2*k+1], w8[2*k], (k == 0), 2'(w), 1'b1});
`ifdef CONV_SER_PARITY_EN
         q.push_back('{1'b1, ^w8, 1'b0, 2'(w), 1'b1});
`endif
         m_ptr = (w + 1) % N;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_outs", outs_now(), 32'd0);
      chk("rst_ready", 32'(bus.REQ_READY), 32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.REQ_VALID = 4'b1111;
      bus.REQ_DATA  = '0;
      tbl[0] = '{2, 8'hB4, 4'b0100, '{2'b00, 2'b01, 2'b11, 2'b10}, 1'b0};
      tbl[1] = '{1, 8'hB5, 4'b0010, '{2'b01, 2'b01, 2'b11, 2'b10}, 1'b1};
      tbl[2] = '{0, 8'h00, 4'b0001, '{2'b00, 2'b00, 2'b00, 2'b00}, 1'b0};
      tbl[3] = '{3, 8'hFF, 4'b1000, '{2'b11, 2'b11, 2'b11, 2'b11}, 1'b0};
      tbl[4] = '{1, 8'hA5, 4'b0010, '{2'b01, 2'b01, 2'b10, 2'b10}, 1'b0};
      tbl[5] = '{3, 8'h1C, 4'b1000, '{2'b00, 2'b11, 2'b01, 2'b00}, 1'b1};

      // Reset held with every channel requesting: nothing may come out.
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("hold_rst_outs", outs_now(), 32'd0);
      chk("hold_rst_ready", 32'(bus.REQ_READY), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Fairness: all channels valid for 8 frames.
      for (int c = 0; c < 8 * PERIOD; c++) cycle(4'b1111, $urandom);
      chk("fair_count", 32'(dut_grants.size()), 32'd8);
      for (int g = 0; g < 8 && g < dut_grants.size(); g++) begin
         chk("fair_order", 32'(dut_grants[g]), 32'(g % 4));
         if (g > 0) chk("fair_period", 32'(dut_gcyc[g] - dut_gcyc[g-1]), 32'(PERIOD));
      end

      // Table-driven single frames.
      do_reset();
      bus.REQ_VALID = 4'b0000;
      for (int t = 0; t < 6; t++) begin
         bus.REQ_VALID = 4'b0001 << tbl[t].ch;
         bus.REQ_DATA  = $urandom;
         bus.REQ_DATA[tbl[t].ch*8 +: 8] = tbl[t].word;
         #1;
         chk("tbl_ready", 32'(bus.REQ_READY), 32'(tbl[t].ready));
         chk("tbl_idle", outs_now(), 32'd0);
         @(negedge clk);
         bus.REQ_VALID = 4'b0000;
         for (int k = 0; k < 4; k++) begin
            bus.REQ_DATA = $urandom;
            #1;
            chk("tbl_beat", outs_now(),
                32'({tbl[t].pairs[k], (k == 0), 2'(tbl[t].ch), 1'b1}));
            chk("tbl_busy_ready", 32'(bus.REQ_READY), 32'd0);
            @(negedge clk);
         end
`ifdef CONV_SER_PARITY_EN
         #1;
         chk("tbl_parity", outs_now(), 32'({1'b1, tbl[t].par, 1'b0, 2'(tbl[t].ch), 1'b1}));
         @(negedge clk);
`endif
         #1;
         chk("tbl_gap", outs_now(), 32'd0);
         @(negedge clk);
      end

      // Mid-frame requests and data changes are ignored until IDLE.
      do_reset();
      cycle(4'b0001, 32'h0000_00B4);
      for (int c = 0; c < PERIOD - 1; c++) cycle(4'b0011, $urandom);
      cycle(4'b0011, $urandom);
      chk("mid_next_grant", 32'(dut_grants[$]), 32'd1);
      for (int c = 0; c < PERIOD; c++) cycle(4'b0000, $urandom);

      // Abort: reset at the second beat of a frame.
      cycle(4'b1111, $urandom);
      cycle(4'b1111, $urandom);
      rst_n = 1'b0;
      #1;
      chk("abort_outs", outs_now(), 32'd0);
      chk("abort_ready", 32'(bus.REQ_READY), 32'd0);
      model_reset();
      @(negedge clk);
      chk("abort_hold", outs_now(), 32'd0);
      rst_n = 1'b1;
      cycle(4'b0000, $urandom);
      cycle(4'b0000, $urandom);
      cycle(4'b1111, $urandom);
      chk("abort_next_grant", 32'(dut_grants[$]), 32'd0);

      // Random traffic against the frame model.
      for (int c = 0; c < 800; c++) cycle(4'($urandom_range(0, 15)), $urandom);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
